// File: rtl/mod5_tx_if.sv
// Handshake and serial-output bundle between a word source and the mod-5
// transmitter; the transmitter takes the slave side.
interface mod5_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data;
    logic             data_valid;
    logic             last;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, data, data_valid, last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, data, data_valid, last, busy
    );
endinterface

// File: rtl/mod5_tx.sv
// Serial transmitter: shifts a payload out MSB first and appends a 3-bit
// check field so every frame, read as a binary number, is divisible by 5.
module mod5_tx #(
    parameter int WIDTH = 8
) (
    input  logic     CLK,
    input  logic     nRST,
    mod5_tx_if.slave bus
);
    // The counter must also reach 2 in CHECK, even when WIDTH is 1.
    localparam int CNT_W = ($clog2(WIDTH + 1) < 2) ? 2 : $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST_BIT = CNT_W'(WIDTH - 1);

    function automatic logic [2:0] mod5_step(input logic [2:0] rem, input logic bit_in);
        logic [3:0] t;
        t = {rem, 1'b0} + {3'b000, bit_in};
        if (t >= 4'd5) begin
            t = t - 4'd5;
        end else begin
            t = t;
        end
        return 3'(t);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       rem_q,   rem_d;
    logic [2:0]       chk_q,   chk_d;

    logic             in_ready_s;
    logic             accept_s;
    logic [2:0]       rem_step_s;
    logic             data_s;
    logic             data_valid_s;
    logic             last_s;

    assign in_ready_s = (state_q == ST_IDLE) ||
                        ((state_q == ST_CHECK) && (cnt_q == CNT_TWO));
    assign accept_s   = bus.in_valid && in_ready_s;
    assign rem_step_s = mod5_step(rem_q, shreg_q[WIDTH-1]);

    // Next-state logic for the frame sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        chk_d   = chk_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shreg_d = bus.in_data;
                    cnt_d   = CNT_ZERO;
                    rem_d   = 3'd0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                rem_d   = rem_step_s;
                shreg_d = shreg_q << 1;
                if (cnt_q == CNT_LAST_BIT) begin
                    chk_d   = mod5_step(rem_step_s, 1'b0);
                    cnt_d   = CNT_ZERO;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (cnt_q != CNT_TWO) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (accept_s) begin
                    shreg_d = bus.in_data;
                    cnt_d   = CNT_ZERO;
                    rem_d   = 3'd0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= CNT_ZERO;
            rem_q   <= 3'd0;
            chk_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            chk_q   <= chk_d;
        end
    end

    // Serial output decode; check bits go out MSB first.
    always_comb begin
        data_s       = 1'b0;
        data_valid_s = 1'b0;
        last_s       = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                data_s       = shreg_q[WIDTH-1];
                data_valid_s = 1'b1;
            end
            ST_CHECK: begin
                data_valid_s = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    data_s = chk_q[2];
                end else if (cnt_q == CNT_ONE) begin
                    data_s = chk_q[1];
                end else begin
                    data_s = chk_q[0];
                    last_s = (cnt_q == CNT_TWO);
                end
            end
            default: begin
                data_s       = 1'b0;
                data_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.data       = data_s;
    assign bus.data_valid = data_valid_s;
    assign bus.last       = last_s;
    assign bus.busy       = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
endmodule

// File: tb/tb_mod5_tx.sv
// Randomised bench for mod5_tx: a frame-level queue model predicts every
// output bit, and a software mod-5 receiver checks divisibility of each frame.
module tb_mod5_tx;
    localparam int W  = 8;
    localparam int FL = W + 3;

    logic clk;
    logic nRST;

    mod5_tx_if #(.WIDTH(W)) intf ();

    mod5_tx #(.WIDTH(W)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit       exp_q[$];
    logic     mdl_acc;
    logic [FL-1:0] frames_q[$];
    logic [FL-1:0] cap;
    int       run_len;
    int       last_run;
    int       rx_state;
    bit       check_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as a number: payload followed by a check field equal to 2P mod 5.
    function automatic logic [31:0] frame_of(input logic [W-1:0] p);
        int c;
        c = (2 * int'(p)) % 5;
        return (32'(p) << 3) + 32'(c);
    endfunction

    // Reference model: the queue holds the bits still to appear on data.
    initial begin
        mdl_acc = 1'b0;
        forever begin
            @(posedge clk or negedge nRST);
            if (!nRST) begin
                exp_q.delete();
                mdl_acc = 1'b0;
            end else begin
                logic [31:0] f;
                bit acc;
                acc = intf.in_valid && (exp_q.size() <= 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc) begin
                    f = frame_of(intf.in_data);
                    for (int b = FL - 1; b >= 0; b--) exp_q.push_back(f[b]);
                end
                mdl_acc = acc;
            end
        end
    end

    // Per-cycle compare, frame capture and loopback receiver.
    initial begin
        cap = '0; run_len = 0; last_run = 0; rx_state = 0;
        forever begin
            @(negedge clk);
            if (check_en) begin
                logic [4:0] e;
                int n;
                n = exp_q.size();
                e = {(n > 0) ? exp_q[0] : 1'b0, n > 0, n == 1, n > 0, n <= 1};
                check("outputs{data,dv,last,busy,rdy}",
                      32'({intf.data, intf.data_valid, intf.last, intf.busy, intf.in_ready}),
                      32'(e));
            end
            if (!nRST) begin
                cap = '0; run_len = 0; rx_state = 0;
            end else if (intf.data_valid) begin
                cap      = {cap[FL-2:0], intf.data};
                rx_state = (2 * rx_state + int'(intf.data)) % 5;
                run_len++;
                if (intf.last) begin
                    frames_q.push_back(cap);
                    check("rx_accept_after_last", 32'(rx_state), 32'd0);
                end
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
                if (check_en) check("rx_idle_in_s0", 32'(rx_state), 32'd0);
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit hold);
        bit got;
        got = 1'b0;
        intf.in_valid = 1'b1;
        intf.in_data  = w;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            got = mdl_acc;
        end
        if (!got) check("accept_timeout", 32'd1, 32'd0);
        if (!hold) intf.in_valid = 1'b0;
        intf.in_data = W'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        check_en      = 1'b0;
        nRST          = 1'b0;
        intf.in_valid = 1'b0;
        intf.in_data  = '0;

        check("model_frame_07", frame_of(8'h07), 32'h03C);
        check("model_frame_ff", frame_of(8'hFF), 32'h7F8);
        check("model_frame_01", frame_of(8'h01), 32'h00A);

        #2;
        check("reset_outputs",
              32'({intf.data, intf.data_valid, intf.last, intf.busy, intf.in_ready}),
              32'b00001);
        @(negedge clk);
        @(negedge clk);
        nRST     = 1'b1;
        check_en = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h07, 1'b0); wait_idle();
        check("frame_07_bits", 32'(frames_q[$]), 32'h03C);
        check("frame_07_len", 32'(last_run), 32'(FL));
        send(8'h00, 1'b0); wait_idle();
        check("frame_00_bits", 32'(frames_q[$]), 32'h000);
        send(8'hFF, 1'b0); wait_idle();
        check("frame_ff_bits", 32'(frames_q[$]), 32'h7F8);

        send(8'h07, 1'b1);
        send(8'h01, 1'b0);
        wait_idle();
        check("b2b_first", 32'(frames_q[$-1]), 32'h03C);
        check("b2b_second", 32'(frames_q[$]), 32'h00A);
        check("b2b_contiguous", 32'(last_run), 32'(2 * FL));

        send(8'hA5, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        nRST = 1'b0;
        #1;
        check("midframe_reset_outputs",
              32'({intf.data, intf.data_valid, intf.last, intf.busy, intf.in_ready}),
              32'b00001);
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(intf.in_ready), 32'd1);
        send(8'h01, 1'b0); wait_idle();
        check("post_reset_frame_01", 32'(frames_q[$]), 32'h00A);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            send(w, 1'b1);
        end
        intf.in_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] w;
            int gap;
            w   = W'($urandom);
            gap = $urandom_range(0, 3);
            send(w, 1'b0);
            if (gap > 0) begin
                wait_idle();
                repeat (gap) @(negedge clk);
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
